// File: rtl/press_pkg.sv
// Shared types and constants for the push-button press event handshake.
package press_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } offer_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 100000;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, mismatch-run debouncer and a registered
// rise pulse that coincides with the stable level going high.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The level flips only on the edge after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          level <= sync2;
          rise  <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/press_event_handshake.sv
// Debounced push-button presses held pending per button and offered one at a
// time, lowest index first, over a registered valid/ready handshake.
module press_event_handshake
  import press_pkg::*;
#(
  parameter int NUM_BUTTONS     = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int ID_W            = $clog2(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic                   ev_valid,
  output logic [ID_W-1:0]        ev_id,
  input  logic                   ev_ready,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] overflow,
  input  logic                   clear_overflow
);

  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] pending;
  logic [NUM_BUTTONS-1:0] ack;
  offer_state_t           state;

  function automatic logic [ID_W-1:0] lowest_index(input logic [NUM_BUTTONS-1:0] v);
    lowest_index = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = ID_W'(i);
    end
  endfunction

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_raw[g]),
      .level  (btn_level[g]),
      .rise   (rise[g])
    );
  end

  // One-hot view of the handshake completing this cycle.
  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      ack[i] = ev_valid && ev_ready && (ev_id == ID_W'(i));
    end
  end

  // A rise re-arms pending even while it is being acknowledged; only a rise onto
  // an un-acknowledged pending event counts as overflow, and the clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending <= (pending & ~ack) | rise;
      if (clear_overflow) begin
        overflow <= '0;
      end else begin
        overflow <= overflow | (rise & pending & ~ack);
      end
    end
  end

  // Offer FSM; valid drops for one cycle after each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ev_valid <= 1'b0;
      ev_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            ev_id    <= lowest_index(pending);
            ev_valid <= 1'b1;
            state    <= OFFER;
          end
        end
        OFFER: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          ev_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_event_handshake.sv
// Directed scenarios plus a randomized run, checked every cycle against a
// behavioural model built from raw-sample history windows.
module tb_press_event_handshake;
  import press_pkg::*;

  localparam int NB = 5;
  localparam int D  = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic          ev_ready = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          ev_valid;
  logic [IW-1:0] ev_id;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] overflow;

  press_event_handshake #(
    .NUM_BUTTONS(NB),
    .DEBOUNCE_CYCLES(D),
    .ID_W(IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .ev_valid      (ev_valid),
    .ev_id         (ev_id),
    .ev_ready      (ev_ready),
    .btn_level     (btn_level),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int offers  = 0;
  int base;
  logic prev_valid = 1'b0;

  // Reference model: raw history per button (bit k = raw sampled k edges ago).
  logic [D+2:0]  rh [NB];
  logic [NB-1:0] m_level, m_rise, m_pend, m_ovf;
  logic          m_valid;
  logic [IW-1:0] m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) rh[b] = '0;
    m_level = '0; m_rise = '0; m_pend = '0; m_ovf = '0;
    m_valid = 1'b0; m_id = '0;
    prev_valid = 1'b0;
  endtask

  task automatic model_edge(input logic [NB-1:0] raw, input logic rdy, input logic clr);
    logic [NB-1:0] acked;
    logic          flip;
    logic [NB-1:0] old_pend;
    old_pend = m_pend;
    for (int i = 0; i < NB; i++) acked[i] = m_valid && rdy && (int'(m_id) == i);
    for (int i = 0; i < NB; i++) begin
      if (m_rise[i]) m_pend[i] = 1'b1;
      else if (acked[i]) m_pend[i] = 1'b0;
      if (clr) m_ovf[i] = 1'b0;
      else if (m_rise[i] && old_pend[i] && !acked[i]) m_ovf[i] = 1'b1;
    end
    if (!m_valid) begin
      for (int i = NB - 1; i >= 0; i--) begin
        if (old_pend[i]) begin
          m_valid = 1'b1;
          m_id = IW'(i);
        end
      end
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    for (int b = 0; b < NB; b++) begin
      rh[b] = {rh[b][D+1:0], raw[b]};
      // Synced sample at this edge is the raw value from two edges ago;
      // the level flips once D+1 successive synced samples disagree with it.
      flip = 1'b1;
      for (int k = 2; k <= D + 2; k++) if (rh[b][k] == m_level[b]) flip = 1'b0;
      if (flip) m_level[b] = ~m_level[b];
      m_rise[b] = flip && m_level[b];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(btn_raw, ev_ready, clear_overflow);
    #1;
    if (ev_valid === 1'b1 && prev_valid !== 1'b1) offers++;
    prev_valid = ev_valid;
    chk("btn_level", 32'(btn_level), 32'(m_level));
    chk("ev_valid", 32'(ev_valid), 32'(m_valid));
    if (m_valid) chk("ev_id", 32'(ev_id), 32'(m_id));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input int lim);
    int k;
    k = 0;
    while (ev_valid !== 1'b1 && k < lim) begin
      step();
      k++;
    end
    chk("wait_valid", 32'(ev_valid), 32'd1);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_id", 32'(ev_id), 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    #11 rst_n = 1'b1;

    // Clean press on button L with latency checks.
    btn_raw[BTN_L] = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      step();
      if (e == 5) chk("lvl_e5", 32'(btn_level[BTN_L]), 32'd0);
      if (e == 6) chk("lvl_e6", 32'(btn_level[BTN_L]), 32'd1);
      if (e == 7) chk("valid_e7", 32'(ev_valid), 32'd0);
      if (e == 8) begin
        chk("valid_e8", 32'(ev_valid), 32'd1);
        chk("id_e8", 32'(ev_id), 32'd2);
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_valid", 32'(ev_valid), 32'd1);
      chk("hold_id", 32'(ev_id), 32'd2);
    end
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    chk("ack_drop", 32'(ev_valid), 32'd0);
    btn_raw[BTN_L] = 1'b0;
    run(12);

    // Bounce on button C: 3 high, 1 low, 3 high, then low.
    btn_raw[BTN_C] = 1'b1; run(3);
    btn_raw[BTN_C] = 1'b0; run(1);
    btn_raw[BTN_C] = 1'b1; run(3);
    btn_raw[BTN_C] = 1'b0; run(15);
    chk("bounce_level", 32'(btn_level), 32'd0);
    chk("bounce_valid", 32'(ev_valid), 32'd0);

    // Simultaneous U and R with ready tied high.
    ev_ready = 1'b1;
    btn_raw[BTN_U] = 1'b1;
    btn_raw[BTN_R] = 1'b1;
    wait_valid(20);
    chk("sim_first", 32'(ev_id), 32'd1);
    step();
    chk("sim_gap", 32'(ev_valid), 32'd0);
    step();
    chk("sim_second_v", 32'(ev_valid), 32'd1);
    chk("sim_second_id", 32'(ev_id), 32'd3);
    base = offers;
    run(15);
    chk("sim_no_more", 32'(offers - base), 32'd0);
    btn_raw = '0;
    run(12);
    ev_ready = 1'b0;

    // Overflow on button D: press, release, re-press while unacknowledged.
    base = offers;
    btn_raw[BTN_D] = 1'b1; run(10);
    btn_raw[BTN_D] = 1'b0; run(10);
    btn_raw[BTN_D] = 1'b1; run(10);
    chk("ovf_set", 32'(overflow[BTN_D]), 32'd1);
    chk("ovf_one_offer", 32'(offers - base), 32'd1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    btn_raw[BTN_D] = 1'b0;
    run(12);
    chk("ovf_merged", 32'(offers - base), 32'd1);

    // Re-press of button C whose rise lands on the ack edge.
    btn_raw[BTN_C] = 1'b1;
    wait_valid(20);
    chk("rep_id", 32'(ev_id), 32'd0);
    btn_raw[BTN_C] = 1'b0; run(10);
    btn_raw[BTN_C] = 1'b1; run(7);
    chk("rep_still", 32'(ev_valid), 32'd1);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    chk("rep_ackdrop", 32'(ev_valid), 32'd0);
    step();
    chk("rep_second_v", 32'(ev_valid), 32'd1);
    chk("rep_second_id", 32'(ev_id), 32'd0);
    chk("rep_no_ovf", 32'(overflow[BTN_C]), 32'd0);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    btn_raw[BTN_C] = 1'b0;
    run(12);

    // Randomized buttons, ready and clears.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 7) == 0) btn_raw[b] = ~btn_raw[b];
      ev_ready = 1'($urandom_range(0, 1));
      clear_overflow = ($urandom_range(0, 15) == 0);
      step();
    end
    btn_raw = '0;
    clear_overflow = 1'b0;
    ev_ready = 1'b1;
    run(30);
    ev_ready = 1'b0;

    // Reset asserted mid-offer with no clock edge.
    btn_raw[BTN_R] = 1'b1;
    wait_valid(20);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ev_valid), 32'd0);
    chk("mid_rst_level", 32'(btn_level), 32'd0);
    chk("mid_rst_pending", 32'(dut.pending), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    model_reset();
    btn_raw = '0;
    @(negedge clk);
    rst_n = 1'b1;
    base = offers;
    run(15);
    chk("post_rst_none", 32'(offers - base), 32'd0);
    chk("post_rst_valid", 32'(ev_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
